// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits needed to count 0..value-1; value is at least 2 here.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register and bit counter: loads a word, shifts it toward the output end,
// and flags the first and last bit of the frame.
module piso_shift_core
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  output logic             bit_o,
  output logic             first_o,
  output logic             last_o
);

  localparam int CNT_W = clog2(WIDTH);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o  = (cnt_q == CNT_W'(WIDTH - 1));
  assign first_o = (cnt_q == CNT_W'(0));
  assign bit_o   = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

  // Load has priority over shift; the counter wraps to 0 after the last bit.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sreg_d = load_data_i;
      cnt_d  = CNT_W'(0);
    end else if (shift_i) begin
      if (LSB_FIRST) begin
        sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      end else begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
      end
      if (last_o) begin
        cnt_d = CNT_W'(0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      sreg_d = sreg_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer for gapless
// back-to-back frames, first/last-bit markers and a shift enable for pausing.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             shift_en_i,
  output logic             sout_o,
  output logic             sout_valid_o,
  output logic             frame_start_o,
  output logic             frame_last_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic             accept_s;
  logic             in_shift_s;
  logic             core_load_s;
  logic             core_shift_s;
  logic [WIDTH-1:0] core_data_s;
  logic             core_bit_s;
  logic             core_first_s;
  logic             core_last_s;

  piso_shift_core #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (core_load_s),
    .load_data_i (core_data_s),
    .shift_i     (core_shift_s),
    .bit_o       (core_bit_s),
    .first_o     (core_first_s),
    .last_o      (core_last_s)
  );

  // Gating with rst_n keeps the producer from handing over a word during reset.
  assign load_ready_o  = rst_n & ~hold_full_q;
  assign accept_s      = load_valid_i & load_ready_o;
  assign in_shift_s    = (state_q == SHIFT);
  assign sout_o        = in_shift_s ? core_bit_s : IDLE_LEVEL;
  assign sout_valid_o  = in_shift_s & shift_en_i;
  assign frame_start_o = sout_valid_o & core_first_s;
  assign frame_last_o  = sout_valid_o & core_last_s;
  assign busy_o        = in_shift_s | hold_full_q;

  // Next-state logic: idle loads bypass the buffer; the last bit reloads from hold or input.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    core_load_s  = 1'b0;
    core_shift_s = 1'b0;
    core_data_s  = load_data_i;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          core_load_s = 1'b1;
          state_d     = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en_i && core_last_s) begin
          if (hold_full_q) begin
            core_load_s = 1'b1;
            core_data_s = hold_q;
            hold_full_d = 1'b0;
          end else if (accept_s) begin
            core_load_s = 1'b1;
          end else begin
            core_shift_s = 1'b1;
            state_d      = IDLE;
          end
        end else begin
          core_shift_s = shift_en_i;
          if (accept_s) begin
            hold_d      = load_data_i;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: three serializer configurations driven on the falling edge and
// checked 1 ns later against hand-computed bit sequences.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // a: WIDTH=4, MSB first, idle 0
  logic [3:0] a_ld;
  logic a_lv, a_rdy, a_en, a_so, a_sv, a_fs, a_fl, a_bz;
  // b: WIDTH=4, LSB first, idle 1
  logic [3:0] b_ld;
  logic b_lv, b_rdy, b_en, b_so, b_sv, b_fs, b_fl, b_bz;
  // c: WIDTH=8, LSB first, idle 0
  logic [7:0] c_ld;
  logic c_lv, c_rdy, c_en, c_so, c_sv, c_fs, c_fl, c_bz;

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .load_data_i(a_ld), .load_valid_i(a_lv), .load_ready_o(a_rdy),
    .shift_en_i(a_en), .sout_o(a_so), .sout_valid_o(a_sv), .frame_start_o(a_fs),
    .frame_last_o(a_fl), .busy_o(a_bz));

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .load_data_i(b_ld), .load_valid_i(b_lv), .load_ready_o(b_rdy),
    .shift_en_i(b_en), .sout_o(b_so), .sout_valid_o(b_sv), .frame_start_o(b_fs),
    .frame_last_o(b_fl), .busy_o(b_bz));

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .load_data_i(c_ld), .load_valid_i(c_lv), .load_ready_o(c_rdy),
    .shift_en_i(c_en), .sout_o(c_so), .sout_valid_o(c_sv), .frame_start_o(c_fs),
    .frame_last_o(c_fl), .busy_o(c_bz));

  task automatic test_reset();
    logic [5:0] got, exp;
    rst_n = 1'b0;
    a_ld = 4'h0; a_lv = 1'b0; a_en = 1'b1;
    b_ld = 4'h0; b_lv = 1'b0; b_en = 1'b1;
    c_ld = 8'h00; c_lv = 1'b0; c_en = 1'b1;
    #3;
    got = {a_so, a_sv, a_fs, a_fl, a_bz, a_rdy}; exp = 6'b000000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_a: got %b expected %b", got, exp); end
    got = {b_so, b_sv, b_fs, b_fl, b_bz, b_rdy}; exp = 6'b100000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_b: got %b expected %b", got, exp); end
    got = {c_so, c_sv, c_fs, c_fl, c_bz, c_rdy}; exp = 6'b000000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_c: got %b expected %b", got, exp); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    got = {3'b000, a_rdy, b_rdy, c_rdy}; exp = 6'b000111;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL reset_release_ready: got %b expected %b", got, exp); end
  endtask

  task automatic test_single();
    logic [3:0] w;
    logic [4:0] got, exp;
    w = 4'b0110;
    @(negedge clk); a_ld = w; a_lv = 1'b1; a_en = 1'b1; #1;
    got = {2'b00, a_rdy, a_so, a_bz}; exp = 5'b00100;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_pre: got %b expected %b", got, exp); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); a_lv = 1'b0; #1;
      got = {a_so, a_sv, a_fs, a_fl, a_bz};
      exp = {w[3-i], 1'b1, (i == 0), (i == 3), 1'b1};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_bit%0d: got %b expected %b", i, got, exp); end
    end
    @(negedge clk); #1;
    got = {2'b00, a_so, a_sv, a_bz}; exp = 5'b00000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_idle: got %b expected %b", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    logic [4:0] got, exp;
    seq = {4'b0110, 4'b1011};
    @(negedge clk); a_ld = 4'b0110; a_lv = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); a_lv = (i == 0); a_ld = 4'b1011; #1;
      got = {a_so, a_sv, a_fs, a_fl, a_rdy};
      exp = {seq[7-i], 1'b1, (i == 0 || i == 4), (i == 3 || i == 7), !(i >= 1 && i <= 3)};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_bit%0d: got %b expected %b", i, got, exp); end
    end
    a_lv = 1'b0;
    @(negedge clk); #1;
    got = {2'b00, a_so, a_sv, a_bz}; exp = 5'b00000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL b2b_idle: got %b expected %b", got, exp); end
  endtask

  task automatic test_stall();
    logic [6:0] ens, sb;
    logic [2:0] got, exp;
    int lasts;
    ens = 7'b1100011;
    sb  = 7'b0111110;
    lasts = 0;
    @(negedge clk); a_ld = 4'b0110; a_lv = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); a_lv = 1'b0; a_en = ens[6-i]; #1;
      got = {a_so, a_sv, a_fl};
      exp = {sb[6-i], ens[6-i], (i == 6)};
      if (a_fl === 1'b1) lasts++;
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL stall_cyc%0d: got %b expected %b", i, got, exp); end
    end
    n_cmp++; if (lasts !== 1) begin n_err++; $display("FAIL stall_last_count: got %0d expected 1", lasts); end
    @(negedge clk); a_en = 1'b1; #1;
    got = {a_so, a_sv, a_bz}; exp = 3'b000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL stall_idle: got %b expected %b", got, exp); end
  endtask

  task automatic test_lsb_first();
    logic [3:0] wb;
    logic [7:0] wc;
    logic [3:0] got, exp;
    wb = 4'b1011;
    wc = 8'hA5;
    @(negedge clk); b_ld = wb; b_lv = 1'b1; #1;
    n_cmp++; if (b_so !== 1'b1) begin n_err++; $display("FAIL lsb4_idle_level: got %b expected 1", b_so); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); b_lv = 1'b0; #1;
      got = {b_so, b_sv, b_fs, b_fl};
      exp = {wb[i], 1'b1, (i == 0), (i == 3)};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb4_bit%0d: got %b expected %b", i, got, exp); end
    end
    @(negedge clk); #1;
    got = {1'b0, b_so, b_sv, b_bz}; exp = 4'b0100;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb4_idle: got %b expected %b", got, exp); end
    @(negedge clk); c_ld = wc; c_lv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); c_lv = 1'b0; #1;
      got = {c_so, c_sv, c_fs, c_fl};
      exp = {wc[i], 1'b1, (i == 0), (i == 7)};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb8_bit%0d: got %b expected %b", i, got, exp); end
    end
    @(negedge clk); #1;
    got = {1'b0, c_so, c_sv, c_bz}; exp = 4'b0000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL lsb8_idle: got %b expected %b", got, exp); end
  endtask

  task automatic test_direct_load();
    logic [7:0] seq;
    logic [4:0] got, exp;
    seq = {4'b0001, 4'b1111};
    @(negedge clk); a_ld = 4'b0001; a_lv = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); a_lv = (i == 3); a_ld = 4'b1111; #1;
      got = {a_so, a_sv, a_fs, a_fl, a_rdy};
      exp = {seq[7-i], 1'b1, (i == 0 || i == 4), (i == 3 || i == 7), 1'b1};
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL direct_bit%0d: got %b expected %b", i, got, exp); end
    end
    a_lv = 1'b0;
    @(negedge clk); #1;
    got = {2'b00, a_so, a_sv, a_bz}; exp = 5'b00000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL direct_idle: got %b expected %b", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got, exp;
    @(negedge clk); a_ld = 4'b0110; a_lv = 1'b1; a_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); a_lv = (i == 0); a_ld = 4'b1001;
    end
    @(negedge clk); a_lv = 1'b0; #1;
    got = {a_so, a_sv, a_bz, a_rdy}; exp = 4'b1110;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_pre: got %b expected %b", got, exp); end
    #1; rst_n = 1'b0; #1;
    got = {a_so, a_sv, a_bz, a_rdy}; exp = 4'b0000;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_async: got %b expected %b", got, exp); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; #1;
    got = {2'b00, a_bz, a_rdy}; exp = 4'b0001;
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_release: got %b expected %b", got, exp); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      got = {1'b0, a_so, a_sv, a_bz}; exp = 4'b0000;
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_quiet%0d: got %b expected %b", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_direct_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
